// File: rtl/ofdm_symbol_framer_pkg.sv
// Shared OFDM definitions: default symbol geometry, complex sample type and
// framer FSM state encodings.
package ofdm_symbol_framer_pkg;

  localparam int unsigned N_FFT_DEF  = 128;
  localparam int unsigned CP_LEN_DEF = 32;
  localparam int unsigned DW_DEF     = 16;

  typedef struct packed {
    logic signed [DW_DEF-1:0] re;
    logic signed [DW_DEF-1:0] im;
  } complex_t;

  typedef enum logic [1:0] {
    WR_SYNC    = 2'd0,
    WR_CP_SKIP = 2'd1,
    WR_COLLECT = 2'd2
  } wr_state_e;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

endpackage

// File: rtl/ofdm_symbol_framer_if.sv
// Sample-in / symbol-out streaming bus of the OFDM symbol framer.
interface ofdm_symbol_framer_if #(
  parameter int unsigned DW = ofdm_symbol_framer_pkg::DW_DEF
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sym_start;
  logic signed [DW-1:0] in_real;
  logic signed [DW-1:0] in_imag;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_real;
  logic signed [DW-1:0] out_imag;
  logic                 out_first;
  logic                 out_last;
  logic                 err_resync;

  // Environment side: sample source and FFT sink
  modport master (
    output in_valid, in_sym_start, in_real, in_imag, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_first, out_last, err_resync
  );

  // Framer side
  modport slave (
    input  in_valid, in_sym_start, in_real, in_imag, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_first, out_last, err_resync
  );

endinterface

// File: rtl/ofdm_symbol_framer_pingpong_ram.sv
// Two-bank symbol buffer: bank select is the address MSB, one write port and
// one registered read port whose register is cleared by reset.
module ofdm_pingpong_ram #(
  parameter int unsigned N_FFT = ofdm_symbol_framer_pkg::N_FFT_DEF,
  parameter int unsigned DW    = ofdm_symbol_framer_pkg::DW_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_we,
  input  logic [$clog2(2*N_FFT)-1:0]   i_waddr,
  input  logic [2*DW-1:0]              i_wdata,
  input  logic                         i_re,
  input  logic [$clog2(2*N_FFT)-1:0]   i_raddr,
  output logic [2*DW-1:0]              o_rdata
);

  logic [2*DW-1:0] r_mem [2*N_FFT];
  logic [2*DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ofdm_symbol_framer.sv
// Strips the cyclic prefix from each OFDM symbol and streams N_FFT samples per
// symbol to the FFT through a ping-pong buffer, with first/last markers.
module ofdm_symbol_framer
  import ofdm_symbol_framer_pkg::*;
#(
  parameter int unsigned N_FFT  = N_FFT_DEF,
  parameter int unsigned CP_LEN = CP_LEN_DEF,
  parameter int unsigned DW     = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ofdm_symbol_framer_if.slave  bus
);

  localparam int unsigned NW = $clog2(N_FFT);
  localparam int unsigned CW = $clog2(CP_LEN);
  localparam int unsigned AW = NW + 1;

  wr_state_e       r_wr_state, w_wr_state_nxt;
  logic [NW-1:0]   r_wr_cnt, w_wr_cnt_nxt;
  logic [CW-1:0]   r_cp_cnt, w_cp_cnt_nxt;
  logic            r_wr_bank, w_wr_bank_nxt;
  logic [1:0]      r_full, w_full_set, w_full_clr, w_full_nxt;
  logic            r_in_ready, r_err, w_err_nxt, w_we, w_acc;

  rd_state_e       r_rd_state, w_rd_state_nxt;
  logic [NW-1:0]   r_rd_cnt, w_rd_cnt_nxt;
  logic            r_rd_bank, w_rd_bank_nxt, r_rd_done, w_rd_done_nxt;
  logic            r_out_valid, w_out_valid_nxt;
  logic            r_out_first, w_out_first_nxt, r_out_last, w_out_last_nxt;
  logic            w_re;
  logic [AW-1:0]   w_raddr;
  logic [2*DW-1:0] w_rdata;

  assign w_acc = bus.in_valid && r_in_ready;

  // Write side: hunt for symbol start, drop the CP, collect N_FFT samples
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_cnt_nxt   = r_wr_cnt;
    w_cp_cnt_nxt   = r_cp_cnt;
    w_wr_bank_nxt  = r_wr_bank;
    w_full_set     = '0;
    w_err_nxt      = 1'b0;
    w_we           = 1'b0;
    if (w_acc) begin
      case (r_wr_state)
        WR_SYNC: begin
          if (bus.in_sym_start) begin
            w_wr_state_nxt = WR_CP_SKIP;
            w_cp_cnt_nxt   = CW'(1);
          end
        end
        WR_CP_SKIP: begin
          if (bus.in_sym_start) begin
            w_err_nxt    = 1'b1;
            w_cp_cnt_nxt = CW'(1);
          end else if (r_cp_cnt == CW'(CP_LEN - 1)) begin
            w_cp_cnt_nxt   = '0;
            w_wr_state_nxt = WR_COLLECT;
          end else begin
            w_cp_cnt_nxt = r_cp_cnt + CW'(1);
          end
        end
        WR_COLLECT: begin
          if (bus.in_sym_start) begin
            w_err_nxt      = 1'b1;
            w_wr_state_nxt = WR_CP_SKIP;
            w_cp_cnt_nxt   = CW'(1);
            w_wr_cnt_nxt   = '0;
          end else begin
            w_we = 1'b1;
            if (r_wr_cnt == NW'(N_FFT - 1)) begin
              w_wr_cnt_nxt          = '0;
              w_full_set[r_wr_bank] = 1'b1;
              w_wr_bank_nxt         = ~r_wr_bank;
              w_wr_state_nxt        = WR_SYNC;
            end else begin
              w_wr_cnt_nxt = r_wr_cnt + NW'(1);
            end
          end
        end
        default: w_wr_state_nxt = WR_SYNC;
      endcase
    end
  end

  // Read side: drain full banks in fill order, chaining banks without a bubble
  always_comb begin
    w_rd_state_nxt  = r_rd_state;
    w_rd_cnt_nxt    = r_rd_cnt;
    w_rd_bank_nxt   = r_rd_bank;
    w_rd_done_nxt   = r_rd_done;
    w_out_valid_nxt = r_out_valid;
    w_out_first_nxt = r_out_first;
    w_out_last_nxt  = r_out_last;
    w_full_clr      = '0;
    w_re            = 1'b0;
    w_raddr         = {r_rd_bank, r_rd_cnt};
    case (r_rd_state)
      RD_IDLE: begin
        if (r_full[r_rd_bank]) w_rd_state_nxt = RD_STREAM;
      end
      RD_STREAM: begin
        if (!r_rd_done) begin
          if (!r_out_valid || bus.out_ready) begin
            w_re            = 1'b1;
            w_out_valid_nxt = 1'b1;
            w_out_first_nxt = (r_rd_cnt == '0);
            w_out_last_nxt  = (r_rd_cnt == NW'(N_FFT - 1));
            if (r_rd_cnt == NW'(N_FFT - 1)) begin
              w_rd_cnt_nxt  = '0;
              w_rd_done_nxt = 1'b1;
            end else begin
              w_rd_cnt_nxt = r_rd_cnt + NW'(1);
            end
          end
        end else if (bus.out_ready) begin
          w_full_clr[r_rd_bank] = 1'b1;
          w_rd_bank_nxt         = ~r_rd_bank;
          w_rd_done_nxt         = 1'b0;
          if (r_full[~r_rd_bank]) begin
            w_re            = 1'b1;
            w_raddr         = {~r_rd_bank, NW'(0)};
            w_out_valid_nxt = 1'b1;
            w_out_first_nxt = 1'b1;
            w_out_last_nxt  = 1'b0;
            w_rd_cnt_nxt    = NW'(1);
          end else begin
            w_out_valid_nxt = 1'b0;
            w_out_first_nxt = 1'b0;
            w_out_last_nxt  = 1'b0;
            w_rd_state_nxt  = RD_IDLE;
          end
        end
      end
      default: w_rd_state_nxt = RD_IDLE;
    endcase
  end

  assign w_full_nxt = (r_full & ~w_full_clr) | w_full_set;

  // CP samples need no bank, so only collection stalls on a full target bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_state  <= WR_SYNC;
      r_wr_cnt    <= '0;
      r_cp_cnt    <= '0;
      r_wr_bank   <= 1'b0;
      r_full      <= '0;
      r_in_ready  <= 1'b1;
      r_err       <= 1'b0;
      r_rd_state  <= RD_IDLE;
      r_rd_cnt    <= '0;
      r_rd_bank   <= 1'b0;
      r_rd_done   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_wr_state  <= w_wr_state_nxt;
      r_wr_cnt    <= w_wr_cnt_nxt;
      r_cp_cnt    <= w_cp_cnt_nxt;
      r_wr_bank   <= w_wr_bank_nxt;
      r_full      <= w_full_nxt;
      r_in_ready  <= !((w_wr_state_nxt == WR_COLLECT) && w_full_nxt[w_wr_bank_nxt]);
      r_err       <= w_err_nxt;
      r_rd_state  <= w_rd_state_nxt;
      r_rd_cnt    <= w_rd_cnt_nxt;
      r_rd_bank   <= w_rd_bank_nxt;
      r_rd_done   <= w_rd_done_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_first <= w_out_first_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

  ofdm_pingpong_ram #(.N_FFT(N_FFT), .DW(DW)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr ({r_wr_bank, r_wr_cnt}),
    .i_wdata ({bus.in_real, bus.in_imag}),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_first  = r_out_first;
  assign bus.out_last   = r_out_last;
  assign bus.out_real   = w_rdata[2*DW-1:DW];
  assign bus.out_imag   = w_rdata[DW-1:0];
  assign bus.err_resync = r_err;

endmodule

// File: tb/tb_ofdm_symbol_framer.sv
// Directed and randomized-handshake bench for ofdm_symbol_framer.
module tb_ofdm_symbol_framer;
  import ofdm_symbol_framer_pkg::*;

  localparam int N   = 128;
  localparam int CP  = 32;
  localparam int SYM = N + CP;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ofdm_symbol_framer_if #(.DW(16)) bus ();

  ofdm_symbol_framer #(.N_FFT(N), .CP_LEN(CP), .DW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [33:0] q_out[$];
  int          q_cyc[$];
  int err_cnt, acc_total, acc_at_drop, low_cnt;
  bit drop_seen;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes seen at negedge complete on the following rising edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        q_out.push_back({bus.out_real, bus.out_imag, bus.out_first, bus.out_last});
        q_cyc.push_back(cyc);
      end
      if (bus.err_resync) err_cnt++;
      if (bus.in_valid && bus.in_ready) acc_total++;
      if (!bus.in_ready) begin
        low_cnt++;
        if (!drop_seen) begin
          drop_seen   = 1'b1;
          acc_at_drop = acc_total;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic complex_t samp(input logic [7:0] tag, input int j);
    complex_t c;
    c.re = {tag, 8'(j)};
    c.im = {8'(j), tag ^ 8'h5A};
    return c;
  endfunction

  // Output k of a symbol is input sample CP+k of that symbol
  function automatic logic [33:0] exp_word(input logic [7:0] tag, input int k);
    complex_t c;
    c = samp(tag, CP + k);
    return {c.re, c.im, (k == 0), (k == N - 1)};
  endfunction

  task automatic send_sample(input complex_t d, input logic st, input bit rnd);
    int n;
    if (rnd) begin
      n = 0;
      while (n < 6 && $urandom_range(0, 1) == 1) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        n++;
      end
    end
    bus.in_valid     = 1'b1;
    bus.in_sym_start = st;
    bus.in_real      = d.re;
    bus.in_imag      = d.im;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (n > 3000) begin
        total++; bad++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        break;
      end
    end
  endtask

  task automatic send_symbol(input logic [7:0] tag, input int nsamp, input bit rnd);
    for (int j = 0; j < nsamp; j++) send_sample(samp(tag, j), (j == 0), rnd);
    bus.in_valid     = 1'b0;
    bus.in_sym_start = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget);
    int c = 0;
    while (q_out.size() < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_sym_start = 1'b0;
    bus.in_real      = '0;
    bus.in_imag      = '0;
    bus.out_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    q_out.delete();
    q_cyc.delete();
    err_cnt = 0; acc_total = 0; low_cnt = 0; acc_at_drop = -1; drop_seen = 1'b0;
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_sym_start = 1'b0;
    bus.in_real      = '0;
    bus.in_imag      = '0;
    bus.out_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b1)   begin bad++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0)  begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_first !== 1'b0)  begin bad++; $display("FAIL rst_out_first got=%b exp=0", bus.out_first); end
    total++; if (bus.out_last !== 1'b0)   begin bad++; $display("FAIL rst_out_last got=%b exp=0", bus.out_last); end
    total++; if (bus.err_resync !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus.err_resync); end
    total++; if (bus.out_real !== 16'sd0) begin bad++; $display("FAIL rst_out_real got=%h exp=0", bus.out_real); end
    total++; if (bus.out_imag !== 16'sd0) begin bad++; $display("FAIL rst_out_imag got=%h exp=0", bus.out_imag); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b1)  begin bad++; $display("FAIL post_rst_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL post_rst_out_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_single_symbol();
    int acc_c, lat, n;
    logic [33:0] got;
    complex_t junk;
    do_reset();
    bus.out_ready = 1'b1;
    // Samples without a symbol start are dropped while hunting
    for (int j = 0; j < 5; j++) begin
      junk.re = 16'h7E00 + 16'(j);
      junk.im = 16'h8100 + 16'(j);
      send_sample(junk, 1'b0, 1'b0);
    end
    send_symbol(8'h11, SYM, 1'b0);
    acc_c = cyc;
    lat   = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = cyc - acc_c;
        break;
      end
    end
    total++; if (lat !== 2) begin bad++; $display("FAIL single_latency got=%0d exp=2", lat); end
    wait_out(N, 500);
    repeat (10) @(posedge clk);
    #1;
    n = q_out.size();
    total++; if (n !== N) begin bad++; $display("FAIL single_count got=%0d exp=%0d", n, N); end
    for (int k = 0; k < N && q_out.size() != 0; k++) begin
      got = q_out.pop_front();
      total++;
      if (got !== exp_word(8'h11, k)) begin
        bad++; $display("FAIL single_data k=%0d got=%h exp=%h", k, got, exp_word(8'h11, k));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] tags [3];
    logic [33:0] got;
    int gaps, n;
    tags = '{8'hA1, 8'h3C, 8'hF0};
    do_reset();
    bus.out_ready = 1'b1;
    for (int s = 0; s < 3; s++) send_symbol(tags[s], SYM, 1'b0);
    wait_out(3 * N, 600);
    repeat (10) @(posedge clk);
    #1;
    total++; if (low_cnt !== 0) begin bad++; $display("FAIL b2b_in_ready_drop got=%0d low cycles exp=0", low_cnt); end
    n = q_out.size();
    total++; if (n !== 3 * N) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", n, 3 * N); end
    gaps = 0;
    for (int i = 0; i + 1 < q_cyc.size(); i++)
      if ((i % N) != N - 1 && q_cyc[i+1] - q_cyc[i] != 1) gaps++;
    total++; if (gaps !== 0) begin bad++; $display("FAIL b2b_intra_gaps got=%0d exp=0", gaps); end
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < N && q_out.size() != 0; k++) begin
        got = q_out.pop_front();
        total++;
        if (got !== exp_word(tags[s], k)) begin
          bad++; $display("FAIL b2b_data s=%0d k=%0d got=%h exp=%h", s, k, got, exp_word(tags[s], k));
        end
      end
  endtask

  task automatic test_backpressure();
    logic [7:0] tags [3];
    logic [33:0] got;
    complex_t c0;
    int n, d;
    tags = '{8'h21, 8'hB2, 8'h43};
    c0 = samp(8'h21, CP);
    do_reset();
    bus.out_ready = 1'b0;
    fork
      begin
        for (int s = 0; s < 3; s++) send_symbol(tags[s], SYM, 1'b0);
      end
      begin
        repeat (400) @(posedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b1)  begin bad++; $display("FAIL bp_hold_valid got=%b exp=1", bus.out_valid); end
        total++; if (bus.out_real !== c0.re)  begin bad++; $display("FAIL bp_hold_real got=%h exp=%h", bus.out_real, c0.re); end
        total++; if (bus.out_first !== 1'b1)  begin bad++; $display("FAIL bp_hold_first got=%b exp=1", bus.out_first); end
        total++; if (bus.in_ready !== 1'b0)   begin bad++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
        total++; if (acc_at_drop !== 2 * SYM + CP) begin
          bad++; $display("FAIL bp_drop_point got=%0d accepted exp=%0d", acc_at_drop, 2 * SYM + CP);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_out(3 * N, 1500);
    repeat (20) @(posedge clk);
    #1;
    n = q_out.size();
    total++; if (n !== 3 * N) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", n, 3 * N); end
    d = (q_cyc.size() > N) ? q_cyc[N] - q_cyc[N-1] : -1;
    total++; if (d !== 1) begin bad++; $display("FAIL bp_bank_bubble got=%0d cycles exp=1", d); end
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < N && q_out.size() != 0; k++) begin
        got = q_out.pop_front();
        total++;
        if (got !== exp_word(tags[s], k)) begin
          bad++; $display("FAIL bp_data s=%0d k=%0d got=%h exp=%h", s, k, got, exp_word(tags[s], k));
        end
      end
  endtask

  task automatic test_resync();
    logic [33:0] got;
    int n;
    do_reset();
    bus.out_ready = 1'b1;
    send_symbol(8'h5E, CP + 50, 1'b0);
    send_symbol(8'hC3, SYM, 1'b0);
    wait_out(N, 500);
    repeat (20) @(posedge clk);
    #1;
    total++; if (err_cnt !== 1) begin bad++; $display("FAIL resync_err_cycles got=%0d exp=1", err_cnt); end
    n = q_out.size();
    total++; if (n !== N) begin bad++; $display("FAIL resync_count got=%0d exp=%0d", n, N); end
    for (int k = 0; k < N && q_out.size() != 0; k++) begin
      got = q_out.pop_front();
      total++;
      if (got !== exp_word(8'hC3, k)) begin
        bad++; $display("FAIL resync_data k=%0d got=%h exp=%h", k, got, exp_word(8'hC3, k));
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [33:0] got;
    int n;
    do_reset();
    bus.out_ready = 1'b1;
    send_symbol(8'h77, SYM, 1'b0);
    wait_out(64, 300);
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_last !== 1'b0)  begin bad++; $display("FAIL midrst_last got=%b exp=0", bus.out_last); end
    total++; if (bus.in_ready !== 1'b1)  begin bad++; $display("FAIL midrst_in_ready got=%b exp=1", bus.in_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    q_out.delete();
    q_cyc.delete();
    send_symbol(8'h88, SYM, 1'b0);
    wait_out(N, 500);
    repeat (10) @(posedge clk);
    #1;
    n = q_out.size();
    total++; if (n !== N) begin bad++; $display("FAIL midrst_count got=%0d exp=%0d", n, N); end
    for (int k = 0; k < N && q_out.size() != 0; k++) begin
      got = q_out.pop_front();
      total++;
      if (got !== exp_word(8'h88, k)) begin
        bad++; $display("FAIL midrst_data k=%0d got=%h exp=%h", k, got, exp_word(8'h88, k));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] tags [3];
    logic [33:0] got;
    bit done;
    int n;
    tags = '{8'h9D, 8'h06, 8'hE7};
    do_reset();
    done = 1'b0;
    fork
      begin
        for (int s = 0; s < 3; s++) send_symbol(tags[s], SYM, 1'b1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_out(3 * N, 2000);
    repeat (20) @(posedge clk);
    #1;
    n = q_out.size();
    total++; if (n !== 3 * N) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", n, 3 * N); end
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < N && q_out.size() != 0; k++) begin
        got = q_out.pop_front();
        total++;
        if (got !== exp_word(tags[s], k)) begin
          bad++; $display("FAIL rand_data s=%0d k=%0d got=%h exp=%h", s, k, got, exp_word(tags[s], k));
        end
      end
  endtask

  initial begin
    test_reset();
    test_single_symbol();
    test_back_to_back();
    test_backpressure();
    test_resync();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
